// File: rtl/mdio_phy_responder_if.sv
// MDIO pad-side bundle between a Clause 22 management master and a PHY target.
//   mdc : management clock, master -> PHY
//   mdi : MDIO pad value as seen by the PHY, master -> PHY
//   mdo : value the PHY drives onto the pad, PHY -> master
//   mdt : PHY pad tristate control, 1 = released, 0 = driving mdo
interface mdio_phy_responder_if;
    logic mdc;
    logic mdi;
    logic mdo;
    logic mdt;

    modport master (output mdc, output mdi, input mdo, input mdt);
    modport slave  (input mdc, input mdi, output mdo, output mdt);
endinterface

// File: rtl/mdio_phy_responder.sv
// MDIO Clause 22 PHY-side responder. Decodes management frames sampled on
// rising mdc edges (after synchronization into clk) and answers reads.
// Serves the PHY ID registers plus a 4-entry extended bank that is reached
// indirectly through the 0x1E (pointer) / 0x1F (data) register pair.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   mdio       : slave modport (mdc, mdi in; mdo, mdt out)
//   ext_regs   : {A003,A002,A001,A000}
//   ext_wr     : one-clk pulse when an extended register is written
//   ext_wr_idx : index of the written register, valid with ext_wr
//
// state | meaning
// IDLE  | counting preamble ones, waiting for ST bit 0
// ST1   | expecting ST bit 1
// OP0   | first opcode bit
// OP1   | second opcode bit, reject 00/11
// PHY   | shifting PHYAD
// REG   | shifting REGAD, address match and read-data load on last bit
// TA1   | turnaround bit 1 (pad still released)
// TA2   | turnaround bit 2 (PHY drives 0 on a read)
// DATA  | 16 data bits, D15 first; write commit on D0
module mdio_phy_responder #(
    parameter logic [4:0]  PHYAD    = 5'b00001,
    parameter int          PRE_MIN  = 32,
    parameter logic [15:0] PHYID1   = 16'h001C,
    parameter logic [15:0] PHYID2   = 16'hC916,
    parameter logic [63:0] EXT_INIT = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    mdio_phy_responder_if.slave   mdio,
    output logic [63:0]           ext_regs,
    output logic                  ext_wr,
    output logic [1:0]            ext_wr_idx
);
    localparam int PW = $clog2(PRE_MIN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ST1, S_OP0, S_OP1, S_PHY, S_REG, S_TA1, S_TA2, S_DATA
    } state_t;

    state_t        state_q;
    logic          mdc_s1_q, mdc_s2_q, mdc_s3_q;
    logic          mdi_s1_q, mdi_s2_q;
    logic          rise_q, bit_q;
    logic [PW-1:0] pre_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [1:0]    op_q;
    logic [4:0]    phy_q, reg_q;
    logic [15:0]   sh_q, ptr_q;
    logic [63:0]   ext_q;
    logic          ext_wr_q;
    logic [1:0]    ext_wr_idx_q;
    logic          mdo_q, mdt_q;

    logic [4:0]    regad_d;
    logic [15:0]   wdata_d;
    logic [15:0]   rdata_d;
    logic          ptr_ok;

    // REGAD and write data including the bit sampled on the current rise
    assign regad_d = {reg_q[3:0], bit_q};
    assign wdata_d = {sh_q[14:0], bit_q};
    // 0xA000..0xA003 share the upper 14 bits 0x2800
    assign ptr_ok  = (ptr_q[15:2] == 14'h2800);

    always_comb begin
        rdata_d = 16'h0000;
        case (regad_d)
            5'h02:   rdata_d = PHYID1;
            5'h03:   rdata_d = PHYID2;
            5'h1E:   rdata_d = ptr_q;
            5'h1F:   rdata_d = ptr_ok ? ext_q[{ptr_q[1:0], 4'b0000} +: 16] : 16'h0000;
            default: rdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mdc_s1_q     <= 1'b0;
            mdc_s2_q     <= 1'b0;
            mdc_s3_q     <= 1'b0;
            mdi_s1_q     <= 1'b0;
            mdi_s2_q     <= 1'b0;
            rise_q       <= 1'b0;
            bit_q        <= 1'b0;
            pre_cnt_q    <= '0;
            bit_cnt_q    <= 4'd0;
            op_q         <= 2'b00;
            phy_q        <= 5'd0;
            reg_q        <= 5'd0;
            sh_q         <= 16'h0000;
            ptr_q        <= 16'h0000;
            ext_q        <= EXT_INIT;
            ext_wr_q     <= 1'b0;
            ext_wr_idx_q <= 2'd0;
            mdo_q        <= 1'b0;
            mdt_q        <= 1'b1;
        end else begin
            mdc_s1_q <= mdio.mdc;
            mdc_s2_q <= mdc_s1_q;
            mdc_s3_q <= mdc_s2_q;
            mdi_s1_q <= mdio.mdi;
            mdi_s2_q <= mdi_s1_q;
            // registered edge detect; bit_q is the mdi value aligned with it
            rise_q   <= mdc_s2_q & ~mdc_s3_q;
            bit_q    <= mdi_s2_q;
            ext_wr_q <= 1'b0;

            if (rise_q) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bit_q) begin
                            if (pre_cnt_q != PW'(PRE_MIN))
                                pre_cnt_q <= pre_cnt_q + 1'b1;
                        end else begin
                            if (pre_cnt_q == PW'(PRE_MIN))
                                state_q <= S_ST1;
                            pre_cnt_q <= '0;
                        end
                    end
                    S_ST1: state_q <= bit_q ? S_OP0 : S_IDLE;
                    S_OP0: begin
                        op_q[1] <= bit_q;
                        state_q <= S_OP1;
                    end
                    S_OP1: begin
                        op_q[0]   <= bit_q;
                        bit_cnt_q <= 4'd0;
                        state_q   <= (op_q[1] != bit_q) ? S_PHY : S_IDLE;
                    end
                    S_PHY: begin
                        phy_q     <= {phy_q[3:0], bit_q};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd4) begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= S_REG;
                        end
                    end
                    S_REG: begin
                        reg_q     <= regad_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd4) begin
                            bit_cnt_q <= 4'd0;
                            if (phy_q != PHYAD) begin
                                state_q <= S_IDLE;
                            end else begin
                                if (op_q[1])
                                    sh_q <= rdata_d;
                                state_q <= S_TA1;
                            end
                        end
                    end
                    S_TA1: begin
                        if (op_q[1]) begin
                            mdt_q <= 1'b0;
                            mdo_q <= 1'b0;
                        end
                        state_q <= S_TA2;
                    end
                    S_TA2: begin
                        if (op_q[1]) begin
                            mdo_q <= sh_q[15];
                            sh_q  <= {sh_q[14:0], 1'b0};
                        end
                        bit_cnt_q <= 4'd0;
                        state_q   <= S_DATA;
                    end
                    S_DATA: begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (op_q[1]) begin
                            if (bit_cnt_q == 4'd15) begin
                                mdt_q <= 1'b1;
                                mdo_q <= 1'b0;
                            end else begin
                                mdo_q <= sh_q[15];
                                sh_q  <= {sh_q[14:0], 1'b0};
                            end
                        end else begin
                            sh_q <= wdata_d;
                            if (bit_cnt_q == 4'd15) begin
                                if (reg_q == 5'h1E) begin
                                    ptr_q <= wdata_d;
                                end else if (reg_q == 5'h1F && ptr_ok) begin
                                    ext_q[{ptr_q[1:0], 4'b0000} +: 16] <= wdata_d;
                                    ext_wr_q     <= 1'b1;
                                    ext_wr_idx_q <= ptr_q[1:0];
                                end
                            end
                        end
                        if (bit_cnt_q == 4'd15)
                            state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mdio.mdo   = mdo_q;
    assign mdio.mdt   = mdt_q;
    assign ext_regs   = ext_q;
    assign ext_wr     = ext_wr_q;
    assign ext_wr_idx = ext_wr_idx_q;
endmodule
